grant_mux2: RTL and testbench
=============================

# grant_mux2

Two-source packet multiplexer that sits directly downstream of request arbitration. It owns the shared output channel. Two valid/ready sources compete for that channel. The block grants one of them with fixed priority (source 0 wins) and then locks the grant for a whole packet, up to and including the beat marked `last`. Granted beats pass combinationally to a single valid/ready master port.

## Interface
- `DW`, default 8: data width of each beat.
- `STARVE_LIMIT`, default 4: number of consecutive source-0 packets after which a waiting source 1 is served. Range 1..15. Used only with `GRANT_MUX_STARVE_GUARD_EN`.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `s0_valid`  in  1  source 0 beat valid.
- `s0_data`  in  DW  source 0 beat data.
- `s0_last`  in  1  source 0 final beat of packet.
- `s0_ready`  out  1  source 0 beat accepted.
- `s1_valid`, `s1_data`, `s1_last`, `s1_ready`: same as source 0, for source 1.
- `m_valid`  out  1  output beat valid.
- `m_data`  out  DW  output beat data.
- `m_last`  out  1  output final beat of packet.
- `m_ready`  in  1  downstream accepts the beat.
- `gnt`  out  2  one-hot current owner; `00` when idle.

## Operation
- State machine with three states: `IDLE`, `OWN0`, `OWN1`. A state register drives `gnt` (`OWN0` gives `01`, `OWN1` gives `10`, `IDLE` gives `00`). `gnt` is never `11`.
- In `IDLE`:
  - If `s0_valid`, go to `OWN0`.
  - Else if `s1_valid`, go to `OWN1`.
  - Else stay in `IDLE`.
  - All outputs are 0: `m_valid`=0, `s0_ready`=0, `s1_ready`=0. Nothing transfers in `IDLE`.
- In `OWNx`:
  - `m_valid`=`sx_valid`, `m_data`=`sx_data`, `m_last`=`sx_last`, `sx_ready`=`m_ready`.
  - The non-owner's ready is 0.
  - When these are driven from the non-owner or in `IDLE`: `m_data`=0, `m_last`=0.
- A transfer occurs on a cycle with `m_valid && m_ready`. A transfer with `m_last`=1 moves the state to `IDLE`. Any other transfer keeps ownership.
- If the owner drops `sx_valid` mid-packet, ownership is held and `m_valid`=0. No re-arbitration happens until the owner's last beat transfers.
- Simultaneous valids in `IDLE`: source 0 wins unless the starve guard overrides it.
- Reset mid-packet: the next cycle is `IDLE`. The packet is truncated and no `last` is emitted.

## Timing
- Reset values: state `IDLE`, `gnt`=`00`, `m_valid`=0, `m_last`=0, `m_data`=0, `s0_ready`=0, `s1_ready`=0, starve counter 0.
- Arbitration: one cycle in `IDLE`. The first beat can transfer on the cycle after the winner's valid is seen in `IDLE`.
- Data path: zero-cycle combinational pass-through while owned. There are no registers on `data`, `valid` or `ready`.
- Throughput: an N-beat packet with `m_ready` held high occupies N+1 cycles, which is N beats plus one `IDLE` bubble.
- A single-beat packet gives `gnt` the sequence `00`, `0x`, `00`.

## Configuration
- `GRANT_MUX_STARVE_GUARD_EN` defined:
  - A 4-bit counter increments when `IDLE` grants source 0 while `s1_valid`=1.
  - The counter clears when `OWN1` is entered.
  - When the counter equals `STARVE_LIMIT` and `s1_valid`=1 in `IDLE`, the block enters `OWN1` even if `s0_valid`=1.
- Macro undefined:
  - Pure fixed priority. Source 1 can starve indefinitely.
  - The counter is not instantiated.

## Test plan
- Reset mid-packet: assert `rst` during beat 2 of a 4-beat s0 packet. Next cycle: `gnt`=`00`, `m_valid`=0, `s0_ready`=0. A fresh s0 packet then gets `gnt`=`01` after one `IDLE` cycle.
- Simultaneous request: `s0_valid`=`s1_valid`=1 in `IDLE`, each with a 3-beat packet, `m_ready`=1.
  - `gnt`=`01` for 3 cycles, then `00` for 1 cycle.
  - Then `01` again, since s0 stays valid. `s1_ready`=0 throughout.
- Backpressure: in `OWN1` with 2 beats `A5`, `3C`, hold `m_ready`=0 for 3 cycles. `m_data` holds `A5` and `s1_ready`=0. Release: `A5` then `3C` transfer, then `IDLE`.
- Owner gap: s1 owns the channel and drops `s1_valid` for 2 cycles mid-packet while `s0_valid`=1. `gnt` stays `10` and `m_valid`=0. Ownership is retained until s1's last beat.
- Guard (`GRANT_MUX_STARVE_GUARD_EN`, `STARVE_LIMIT`=2): both sources request continuously with 1-beat packets. Grant order: s0, s0, s1, s0, s0, s1.
- Guard disabled, same stimulus: s0 only, and `s1_ready` is never 1.

Source files
------------

// File: rtl/grant_mux2.sv
// grant_mux2: two-source packet mux, fixed priority to s0, grant held until last beat; ports clk/rst, s0_*/s1_* valid/data/last/ready, m_* master, gnt one-hot owner; GRANT_MUX_STARVE_GUARD_EN adds s1 starve guard
module grant_mux2 #(
  parameter int DW = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s0_valid,
  input  logic [DW-1:0] s0_data,
  input  logic          s0_last,
  output logic          s0_ready,
  input  logic          s1_valid,
  input  logic [DW-1:0] s1_data,
  input  logic          s1_last,
  output logic          s1_ready,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  input  logic          m_ready,
  output logic [1:0]    gnt
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t r_state, w_next;
  logic w_own0, w_own1, w_guard;
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limit_check
    $error("grant_mux2: STARVE_LIMIT must be 1..15");
  end
  assign w_own0   = r_state == OWN0;
  assign w_own1   = r_state == OWN1;
  assign gnt      = {w_own1, w_own0};
  assign m_valid  = w_own0 ? s0_valid : w_own1 ? s1_valid : 1'b0;
  assign m_last   = w_own0 ? s0_last  : w_own1 ? s1_last  : 1'b0;
  assign m_data   = w_own0 ? s0_data  : w_own1 ? s1_data  : '0;
  assign s0_ready = w_own0 & m_ready;
  assign s1_ready = w_own1 & m_ready;
  always_comb
    w_next = (r_state == IDLE) ? (w_guard ? OWN1 : s0_valid ? OWN0 : s1_valid ? OWN1 : IDLE)
           : (m_valid && m_ready && m_last) ? IDLE : r_state;
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_next;
`ifdef GRANT_MUX_STARVE_GUARD_EN
  logic [3:0] r_starve;
  assign w_guard = r_state == IDLE && s1_valid && r_starve == 4'(STARVE_LIMIT);
  always_ff @(posedge clk)
    if (rst)
      r_starve <= '0;
    else if (r_state == IDLE && w_next == OWN1)
      r_starve <= '0;
    else if (r_state == IDLE && w_next == OWN0 && s1_valid)
      r_starve <= r_starve + 4'd1;
`else
  assign w_guard = 1'b0;
`endif
endmodule

// File: tb/tb_grant_mux2.sv
// tb_grant_mux2: directed and random checks of grant_mux2 against a per-cycle behavioural model
module tb_grant_mux2;
  localparam int LIM = 2;
`ifdef GRANT_MUX_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, s0_valid, s0_last, s0_ready, s1_valid, s1_last, s1_ready;
  logic m_valid, m_last, m_ready;
  logic [7:0] s0_data, s1_data, m_data;
  logic [1:0] gnt;
  int errors = 0, checks = 0;
  int own = 0, cnt = 0;
  bit x0, x1;
  grant_mux2 #(.DW(8), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_data(s0_data), .s0_last(s0_last), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_data(s1_data), .s1_last(s1_last), .s1_ready(s1_ready),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready), .gnt(gnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic set(input logic r, v0, l0, input logic [7:0] d0, input logic v1, l1, input logic [7:0] d1, input logic mr);
    rst = r; s0_valid = v0; s0_last = l0; s0_data = d0;
    s1_valid = v1; s1_last = l1; s1_data = d1; m_ready = mr;
  endtask
  task automatic step(input string tag);
    logic [1:0] eg;
    logic ev, el, er0, er1;
    logic [7:0] ed;
    #1;
    eg  = own == 1 ? 2'b01 : own == 2 ? 2'b10 : 2'b00;
    ev  = own == 1 ? s0_valid : own == 2 ? s1_valid : 1'b0;
    el  = own == 1 ? s0_last : own == 2 ? s1_last : 1'b0;
    ed  = own == 1 ? s0_data : own == 2 ? s1_data : 8'h00;
    er0 = own == 1 && m_ready;
    er1 = own == 2 && m_ready;
    checks++;
    assert ({gnt, m_valid, m_last, m_data, s0_ready, s1_ready} === {eg, ev, el, ed, er0, er1}) else begin
      errors++;
      $error("FAIL %s: observed gnt=%b v=%b l=%b d=%h r0=%b r1=%b expected gnt=%b v=%b l=%b d=%h r0=%b r1=%b",
             tag, gnt, m_valid, m_last, m_data, s0_ready, s1_ready, eg, ev, el, ed, er0, er1);
    end
    x0 = er0 && s0_valid;
    x1 = er1 && s1_valid;
    @(posedge clk);
    if (rst) begin
      own = 0; cnt = 0;
    end else if (own == 0) begin
      if (GUARD && cnt == LIM && s1_valid) begin own = 2; cnt = 0; end
      else if (s0_valid) begin own = 1; if (s1_valid) cnt++; end
      else if (s1_valid) begin own = 2; cnt = 0; end
    end else if (ev && m_ready && el)
      own = 0;
    #1;
  endtask
  initial begin
    int b0, b1;
    logic [1:0] sim_tbl [9];
    logic [1:0] grd_tbl [12];
    sim_tbl = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00};
    for (int i = 0; i < 12; i++)
      grd_tbl[i] = (i % 2 == 0) ? 2'b00 : (GUARD && i % 6 == 5) ? 2'b10 : 2'b01;
    set(1, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); @(posedge clk); #1;
    set(0, 0, 0, 8'h11, 0, 0, 8'h22, 1);
    step("reset_state");
    chk("reset_gnt", {6'd0, gnt}, 8'h00);
    // reset during beat 2 of a 4-beat s0 packet
    set(0, 1, 0, 8'h10, 0, 0, 0, 1); step("rmp_idle");
    set(0, 1, 0, 8'h11, 0, 0, 0, 1); step("rmp_beat1");
    set(1, 1, 0, 8'h12, 0, 0, 0, 1); step("rmp_beat2_rst");
    chk("rmp_gnt_after_rst", {6'd0, gnt}, 8'h00);
    set(0, 1, 0, 8'h20, 0, 0, 0, 1); step("rmp_idle_again");
    chk("rmp_gnt_fresh", {6'd0, gnt}, 8'h01);
    set(0, 1, 1, 8'h21, 0, 0, 0, 1); step("rmp_fresh_last");
    // simultaneous 3-beat packets
    set(1, 0, 0, 0, 0, 0, 0, 0); step("sim_rst");
    b0 = 0; b1 = 0;
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("sim_gnt%0d", k), {6'd0, gnt}, {6'd0, sim_tbl[k]});
      set(0, 1, b0 % 3 == 2, 8'(b0), 1, b1 % 3 == 2, 8'(8'h80 + b1), 1);
      step("sim");
      b0 += int'(x0); b1 += int'(x1);
    end
    chk("sim_s1_untouched", 8'(b1), 8'h00);
    // backpressure in OWN1
    set(1, 0, 0, 0, 0, 0, 0, 0); step("bp_rst");
    set(0, 0, 0, 0, 1, 0, 8'hA5, 1); step("bp_idle");
    for (int k = 0; k < 3; k++) begin
      set(0, 0, 0, 0, 1, 0, 8'hA5, 0); step("bp_hold");
      chk("bp_hold_data", m_data, 8'hA5);
    end
    set(0, 0, 0, 0, 1, 0, 8'hA5, 1); step("bp_beat_a5");
    set(0, 0, 0, 0, 1, 1, 8'h3C, 1); step("bp_beat_3c");
    chk("bp_idle_after", {6'd0, gnt}, 8'h00);
    // owner gap while s0 waits
    set(1, 0, 0, 0, 0, 0, 0, 0); step("gap_rst");
    set(0, 0, 0, 0, 1, 0, 8'h40, 1); step("gap_idle");
    set(0, 1, 0, 8'h55, 1, 0, 8'h41, 1); step("gap_beat1");
    for (int k = 0; k < 2; k++) begin
      set(0, 1, 0, 8'h55, 0, 0, 8'h42, 1); step("gap_hole");
      chk("gap_gnt", {6'd0, gnt}, 8'h02);
    end
    set(0, 1, 0, 8'h55, 1, 1, 8'h43, 1); step("gap_last");
    chk("gap_released", {6'd0, gnt}, 8'h00);
    // back-to-back single-beat packets from both sources
    set(1, 0, 0, 0, 0, 0, 0, 0); step("grd_rst");
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("grd_gnt%0d", k), {6'd0, gnt}, {6'd0, grd_tbl[k]});
      set(0, 1, 1, 8'(k), 1, 1, 8'(8'hC0 + k), 1);
      step("grd");
    end
    // random traffic with occasional reset
    for (int k = 0; k < 800; k++) begin
      set($urandom_range(0, 49) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0, 8'($urandom),
          $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 3) != 0);
      step("rand");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
